// File: rtl/bet_ledger_if.sv
// Bus bundle for the bet ledger: keyboard/sensor inputs, slot read port and status flags.
interface bet_ledger_if #(
  parameter int OP_W   = 6,
  parameter int AMT_W  = 2,
  parameter int CNT_W  = 4,
  parameter int SLOT_W = 8
);
  logic              key_valid;
  logic [OP_W-1:0]   key_opcode;
  logic              amt_valid;
  logic [AMT_W-1:0]  amt_value;
  logic              round_done;
  logic [CNT_W-1:0]  rd_idx;
  logic [SLOT_W-1:0] rd_data;
  logic [CNT_W-1:0]  bet_count;
  logic              spin_go;
  logic              full;
  logic              overflow;
  logic              bet_received;
  logic              accept_pulse;

  modport master (
    output key_valid, key_opcode, amt_valid, amt_value, round_done, rd_idx,
    input  rd_data, bet_count, spin_go, full, overflow, bet_received, accept_pulse
  );

  modport slave (
    input  key_valid, key_opcode, amt_valid, amt_value, round_done, rd_idx,
    output rd_data, bet_count, spin_go, full, overflow, bet_received, accept_pulse
  );
endinterface

// File: rtl/bet_ledger.sv
// Roulette bet ledger: collects bets into slots while OPEN, locks them for the spin,
// and wipes the table for one cycle after the processor reports the payout is done.
module bet_ledger #(
  parameter int              DEPTH       = 12,
  parameter int              OP_W        = 6,
  parameter int              AMT_W       = 2,
  parameter int              HOLD_CYCLES = 100_000_000,
  parameter logic [OP_W-1:0] SPIN_OP     = 6'b111110,
  parameter logic [OP_W-1:0] NULL_OP     = 6'b111111,
  localparam int             SLOT_W      = OP_W + AMT_W,
  localparam int             CNT_W       = $clog2(DEPTH + 1)
) (
  input logic          clock,
  input logic          reset_n,
  bet_ledger_if.slave  bus
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {OPEN, LOCKED, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slots_q [DEPTH];
  logic [SLOT_W-1:0] slots_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              accept_q, accept_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              is_bet, is_spin, is_full;
  logic [SLOT_W-1:0] rd_mux;

  assign is_bet  = bus.key_valid && bus.amt_valid &&
                   (bus.key_opcode != SPIN_OP) && (bus.key_opcode != NULL_OP);
  assign is_spin = bus.key_valid && (bus.key_opcode == SPIN_OP);
  assign is_full = (count_q == CNT_W'(DEPTH));

  always_comb begin
    state_d    = state_q;
    slots_d    = slots_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    accept_d   = 1'b0;
    case (state_q)
      OPEN: begin
        if (is_bet) begin
          if (is_full) begin
            overflow_d = 1'b1;
          end else begin
            for (int i = 0; i < DEPTH; i++) begin
              if (count_q == CNT_W'(i)) slots_d[i] = {bus.amt_value, bus.key_opcode};
            end
            count_d  = count_q + CNT_W'(1);
            accept_d = 1'b1;
          end
        end else if (is_spin && (count_q != '0)) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (is_bet) overflow_d = 1'b1;
        if (bus.round_done) state_d = CLEAR;
      end
      CLEAR: begin
        for (int i = 0; i < DEPTH; i++) slots_d[i] = '0;
        count_d    = '0;
        overflow_d = 1'b0;
        state_d    = OPEN;
      end
      default: state_d = OPEN;
    endcase
  end

  // Every accepted bet restarts the stretch so the indicator stays lit after the last one.
  always_comb begin
    hold_d = hold_q;
    if (accept_d) begin
      hold_d = HOLD_W'(HOLD_CYCLES);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= OPEN;
      for (int i = 0; i < DEPTH; i++) slots_q[i] <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      accept_q   <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      slots_q    <= slots_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      accept_q   <= accept_d;
      hold_q     <= hold_d;
    end
  end

  // Indices at or beyond DEPTH match no slot and read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.rd_idx == CNT_W'(i)) rd_mux = slots_q[i];
    end
  end

  assign bus.rd_data      = rd_mux;
  assign bus.bet_count    = count_q;
  assign bus.spin_go      = (state_q == LOCKED);
  assign bus.full         = is_full;
  assign bus.overflow     = overflow_q;
  assign bus.bet_received = (hold_q != '0);
  assign bus.accept_pulse = accept_q;

endmodule

// File: tb/tb_bet_ledger.sv
// Self-checking bench for bet_ledger: directed round scenarios plus randomized traffic
// compared every cycle against a queue-based model of the betting table.
module tb_bet_ledger;

  localparam int DEPTH  = 4;
  localparam int HOLD   = 5;
  localparam int OP_W   = 6;
  localparam int AMT_W  = 2;
  localparam int CNT_W  = 3;
  localparam int SLOT_W = 8;
  localparam logic [OP_W-1:0] SPIN   = 6'b111110;
  localparam logic [OP_W-1:0] NULLOP = 6'b111111;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clock = ~clock;

  bet_ledger_if #(.OP_W(OP_W), .AMT_W(AMT_W), .CNT_W(CNT_W), .SLOT_W(SLOT_W)) bus ();

  bet_ledger #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Model of the table: the stored bets in order, round phase flags and the hold timer.
  logic [SLOT_W-1:0] m_bets[$];
  bit m_locked   = 1'b0;
  bit m_clearing = 1'b0;
  bit m_overflow = 1'b0;
  bit m_accept   = 1'b0;
  int m_hold     = 0;
  bit m_is_bet, m_is_spin;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int model_rd(input int idx);
    if (idx < m_bets.size()) return int'(m_bets[idx]);
    return 0;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_bets.delete();
      m_locked   = 1'b0;
      m_clearing = 1'b0;
      m_overflow = 1'b0;
      m_accept   = 1'b0;
      m_hold     = 0;
    end else begin
      m_is_bet  = bus.key_valid && bus.amt_valid && bus.key_opcode != SPIN && bus.key_opcode != NULLOP;
      m_is_spin = bus.key_valid && bus.key_opcode == SPIN;
      m_accept  = 1'b0;
      if (m_clearing) begin
        m_bets.delete();
        m_overflow = 1'b0;
        m_clearing = 1'b0;
      end else if (m_locked) begin
        if (m_is_bet) m_overflow = 1'b1;
        if (bus.round_done) begin
          m_locked   = 1'b0;
          m_clearing = 1'b1;
        end
      end else if (m_is_bet) begin
        if (m_bets.size() < DEPTH) begin
          m_bets.push_back({bus.amt_value, bus.key_opcode});
          m_accept = 1'b1;
        end else begin
          m_overflow = 1'b1;
        end
      end else if (m_is_spin && m_bets.size() > 0) begin
        m_locked = 1'b1;
      end
      if (m_accept) m_hold = HOLD;
      else if (m_hold > 0) m_hold = m_hold - 1;
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      checkOutput("cmp_bet_count", int'(bus.bet_count), m_bets.size());
      checkOutput("cmp_spin_go", int'(bus.spin_go), int'(m_locked));
      checkOutput("cmp_full", int'(bus.full), int'(m_bets.size() == DEPTH));
      checkOutput("cmp_overflow", int'(bus.overflow), int'(m_overflow));
      checkOutput("cmp_bet_received", int'(bus.bet_received), int'(m_hold > 0));
      checkOutput("cmp_accept_pulse", int'(bus.accept_pulse), int'(m_accept));
      checkOutput("cmp_rd_data", int'(bus.rd_data), model_rd(int'(bus.rd_idx)));
    end
  end

  task automatic applyStimulus(input bit kv, input logic [OP_W-1:0] op, input bit av,
                               input logic [AMT_W-1:0] amt, input bit rdone);
    bus.key_valid  = kv;
    bus.key_opcode = op;
    bus.amt_valid  = av;
    bus.amt_value  = amt;
    bus.round_done = rdone;
    @(posedge clock);
    #1;
    bus.key_valid  = 1'b0;
    bus.amt_valid  = 1'b0;
    bus.round_done = 1'b0;
  endtask

  task automatic placeBet(input logic [OP_W-1:0] op, input logic [AMT_W-1:0] amt);
    applyStimulus(1'b1, op, 1'b1, amt, 1'b0);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    bus.key_valid  = 1'b0;
    bus.key_opcode = '0;
    bus.amt_valid  = 1'b0;
    bus.amt_value  = '0;
    bus.round_done = 1'b0;
    bus.rd_idx     = '0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_bet_count", int'(bus.bet_count), 0);
    checkOutput("rst_spin_go", int'(bus.spin_go), 0);
    checkOutput("rst_bet_received", int'(bus.bet_received), 0);
    checkOutput("rst_accept_pulse", int'(bus.accept_pulse), 0);
    checkOutput("rst_rd_data", int'(bus.rd_data), 0);

    // a) two bets and read-back; first bet taken on the first edge after release
    reset_n = 1'b1;
    placeBet(6'h05, 2'd1);
    checkOutput("a_first_count", int'(bus.bet_count), 1);
    checkOutput("a_first_accept", int'(bus.accept_pulse), 1);
    applyStimulus(1'b1, NULLOP, 1'b1, 2'd3, 1'b0);
    checkOutput("a_null_count", int'(bus.bet_count), 1);
    checkOutput("a_null_overflow", int'(bus.overflow), 0);
    checkOutput("a_null_accept", int'(bus.accept_pulse), 0);
    applyStimulus(1'b1, 6'h0A, 1'b0, 2'd2, 1'b0);
    checkOutput("a_noamt_count", int'(bus.bet_count), 1);
    placeBet(6'h0A, 2'd2);
    checkOutput("a_second_count", int'(bus.bet_count), 2);
    checkOutput("a_second_accept", int'(bus.accept_pulse), 1);
    idleCycles(1);
    checkOutput("a_accept_drop", int'(bus.accept_pulse), 0);
    bus.rd_idx = 3'd0;
    #1 checkOutput("a_rd0", int'(bus.rd_data), 8'h45);
    bus.rd_idx = 3'd1;
    #1 checkOutput("a_rd1", int'(bus.rd_data), 8'h8A);
    bus.rd_idx = 3'd5;
    #1 checkOutput("a_rd_oob", int'(bus.rd_data), 0);

    // b) fill to DEPTH and overflow
    placeBet(6'h01, 2'd3);
    placeBet(6'h02, 2'd0);
    checkOutput("b_count_full", int'(bus.bet_count), 4);
    checkOutput("b_full", int'(bus.full), 1);
    checkOutput("b_no_overflow", int'(bus.overflow), 0);
    bus.rd_idx = 3'd3;
    #1 checkOutput("b_rd3", int'(bus.rd_data), 8'h02);
    placeBet(6'h03, 2'd1);
    checkOutput("b_fifth_count", int'(bus.bet_count), 4);
    checkOutput("b_fifth_overflow", int'(bus.overflow), 1);
    checkOutput("b_fifth_accept", int'(bus.accept_pulse), 0);
    checkOutput("b_rd3_kept", int'(bus.rd_data), 8'h02);

    // d) lock, finish round, one CLEAR cycle ignoring keys
    applyStimulus(1'b1, SPIN, 1'b0, 2'd0, 1'b0);
    checkOutput("d_spin_go", int'(bus.spin_go), 1);
    applyStimulus(1'b0, 6'h00, 1'b0, 2'd0, 1'b1);
    checkOutput("d_clear_spin_go", int'(bus.spin_go), 0);
    placeBet(6'h09, 2'd1);
    checkOutput("d_open_count", int'(bus.bet_count), 0);
    checkOutput("d_open_overflow", int'(bus.overflow), 0);
    checkOutput("d_open_full", int'(bus.full), 0);
    checkOutput("d_clear_accept", int'(bus.accept_pulse), 0);
    bus.rd_idx = 3'd0;
    #1 checkOutput("d_rd0_zero", int'(bus.rd_data), 0);

    // c) empty spin ignored, locked bets overflow
    applyStimulus(1'b1, SPIN, 1'b0, 2'd0, 1'b0);
    checkOutput("c_empty_spin", int'(bus.spin_go), 0);
    placeBet(6'h07, 2'd3);
    checkOutput("c_one_bet", int'(bus.bet_count), 1);
    applyStimulus(1'b1, SPIN, 1'b0, 2'd0, 1'b0);
    checkOutput("c_locked", int'(bus.spin_go), 1);
    placeBet(6'h08, 2'd1);
    checkOutput("c_locked_overflow", int'(bus.overflow), 1);
    checkOutput("c_locked_count", int'(bus.bet_count), 1);
    applyStimulus(1'b1, SPIN, 1'b0, 2'd0, 1'b0);
    checkOutput("c_respin", int'(bus.spin_go), 1);
    applyStimulus(1'b0, 6'h00, 1'b0, 2'd0, 1'b1);
    idleCycles(1);
    checkOutput("c_cleared_count", int'(bus.bet_count), 0);
    checkOutput("c_cleared_overflow", int'(bus.overflow), 0);

    // e) stretch of HOLD cycles, retrigger at cycle 3 extends through cycle 8
    idleCycles(6);
    placeBet(6'h11, 2'd1);
    checkOutput("e_c1", int'(bus.bet_received), 1);
    repeat (2) begin
      idleCycles(1);
      checkOutput("e_c2_3", int'(bus.bet_received), 1);
    end
    placeBet(6'h12, 2'd1);
    checkOutput("e_c4", int'(bus.bet_received), 1);
    repeat (4) begin
      idleCycles(1);
      checkOutput("e_c5_8", int'(bus.bet_received), 1);
    end
    idleCycles(1);
    checkOutput("e_c9", int'(bus.bet_received), 0);

    // f) asynchronous reset while locked with the indicator lit
    placeBet(6'h13, 2'd2);
    applyStimulus(1'b1, SPIN, 1'b0, 2'd0, 1'b0);
    placeBet(6'h14, 2'd3);
    checkOutput("f_pre_spin_go", int'(bus.spin_go), 1);
    checkOutput("f_pre_received", int'(bus.bet_received), 1);
    checkOutput("f_pre_overflow", int'(bus.overflow), 1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("f_spin_go", int'(bus.spin_go), 0);
    checkOutput("f_received", int'(bus.bet_received), 0);
    checkOutput("f_count", int'(bus.bet_count), 0);
    checkOutput("f_overflow", int'(bus.overflow), 0);
    checkOutput("f_accept", int'(bus.accept_pulse), 0);
    checkOutput("f_rd0", int'(bus.rd_data), 0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (HOLD + 2) begin
      idleCycles(1);
      checkOutput("f_post_received", int'(bus.bet_received), 0);
      checkOutput("f_post_spin_go", int'(bus.spin_go), 0);
    end

    // Randomized traffic against the model
    repeat (3000) begin
      logic [OP_W-1:0] op;
      int sel;
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
      sel = $urandom_range(0, 9);
      if (sel < 2) op = SPIN;
      else if (sel == 2) op = NULLOP;
      else op = OP_W'($urandom_range(0, 61));
      bus.rd_idx = CNT_W'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 3) != 0, op, $urandom_range(0, 4) != 0,
                    AMT_W'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bet_ledger.md
BET_LEDGER -- requirements
Module: bet_ledger

Interface
REQ-001 The block SHALL have parameter DEPTH, default 12, giving the number of bet slots (2..64).
REQ-002 The block SHALL have parameter OP_W, default 6, giving the bet opcode width.
REQ-003 The block SHALL have parameter AMT_W, default 2, giving the chip-amount width.
REQ-004 The block SHALL have parameter HOLD_CYCLES, default 100_000_000, giving the bet_received stretch length in cycles.
REQ-005 The block SHALL have parameter SPIN_OP, default 6'b111110, giving the spin opcode.
REQ-006 The block SHALL have parameter NULL_OP, default 6'b111111, giving the no-bet opcode.
REQ-007 The block SHALL define derived widths SLOT_W = OP_W+AMT_W and CNT_W = $clog2(DEPTH+1).
REQ-008 Ports SHALL be, one per line (name, direction, width, meaning):
  clock  in  1  single system clock; all state on rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  key_valid  in  1  one-cycle strobe: new keyboard opcode.
  key_opcode  in  OP_W  decoded keyboard opcode.
  amt_valid  in  1  Arduino colour-sensor reading valid.
  amt_value  in  AMT_W  chip amount from colour sensor.
  round_done  in  1  processor pulse: payout finished.
  rd_idx  in  CNT_W  slot read index.
  rd_data  out  SLOT_W  {amount, opcode} of slot rd_idx; 0 if rd_idx >= DEPTH.
  bet_count  out  CNT_W  number of bets stored.
  spin_go  out  1  high while in LOCKED.
  full  out  1  bet_count == DEPTH.
  overflow  out  1  sticky: bet rejected this round.
  bet_received  out  1  stretched acceptance indicator.
  accept_pulse  out  1  one-cycle pulse per accepted bet.

Function
REQ-009 The FSM SHALL have three states: OPEN, LOCKED and CLEAR.
REQ-010 A bet event SHALL be key_valid & amt_valid & key_opcode != SPIN_OP & key_opcode != NULL_OP.
REQ-011 A spin event SHALL be key_valid & key_opcode == SPIN_OP.
REQ-012 In OPEN, a bet event with bet_count < DEPTH SHALL write {amt_value, key_opcode} to slot[bet_count], increment bet_count, and assert accept_pulse in the next cycle.
REQ-013 In OPEN, a bet event with full = 1 SHALL leave the slots and bet_count unchanged and set overflow.
REQ-014 key_valid with amt_valid = 0, or with key_opcode == NULL_OP, SHALL be ignored without setting any flag.
REQ-015 In OPEN, a spin event with bet_count > 0 SHALL move the FSM to LOCKED; with bet_count == 0 it SHALL be ignored.
REQ-016 In LOCKED, bet events SHALL set overflow and SHALL NOT change the slots; spin events SHALL be ignored.
REQ-017 spin_go SHALL be 1 exactly while the FSM is in LOCKED, with no added latency.
REQ-018 round_done in LOCKED SHALL move the FSM to CLEAR; round_done in OPEN or CLEAR SHALL be ignored.
REQ-019 CLEAR SHALL last exactly one cycle: it zeroes all slots, bet_count and overflow, then returns to OPEN; key inputs in CLEAR SHALL be ignored.
REQ-020 Each accepted bet SHALL load the hold counter with HOLD_CYCLES; bet_received SHALL be 1 while the counter is nonzero and SHALL fall exactly HOLD_CYCLES cycles after the load.
REQ-021 A retrigger during the hold SHALL reload the counter to HOLD_CYCLES.
REQ-022 rd_data SHALL be combinational from rd_idx and the slot array.
REQ-023 bet_count SHALL saturate at DEPTH and SHALL never wrap.

Reset
REQ-024 When reset_n = 0, asynchronously: the FSM SHALL go to OPEN, and all slots, bet_count, overflow, accept_pulse, the hold counter and bet_received SHALL be 0.
REQ-025 Reset asserted mid-hold or in LOCKED SHALL abort the operation, with no residual pulse after release.
REQ-026 The first bet SHALL be accepted on the first rising edge after reset_n goes high.

Verification
REQ-027 The bench SHALL run with DEPTH=4 and HOLD_CYCLES=5 and SHALL cover these scenarios:
  a) Bets 0x05/amt 1, 0x0A/amt 2, then read idx 0,1 -> rd_data 0x45, 0x8A; bet_count=2; accept_pulse once per bet.
  b) Five bets -> bet_count=4, full=1, overflow=1 after the fifth bet, slot[3] unchanged by the fifth bet.
  c) Spin with bet_count=0 -> spin_go stays 0. After one bet, spin -> spin_go=1 next cycle; a bet while LOCKED sets overflow, bet_count stays 1.
  d) round_done in LOCKED -> one CLEAR cycle, then OPEN with bet_count=0, overflow=0, rd_data(0)=0.
  e) Bet at cycle 0 -> bet_received high cycles 1-5; retrigger at cycle 3 -> high through cycle 8.
  f) reset_n low during LOCKED with bet_received high -> all outputs 0 immediately, with no clock edge needed.
